game_mode_ctrl: RTL

GAME_MODE_CTRL -- requirements
Module: game_mode_ctrl

---
 rtl/game_mode_ctrl.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/game_mode_ctrl.sv
// rtl/game_mode_ctrl.sv - game mode sequencer: state timers, scoring, lives, fright mode
// Optional feature macro: GAME_MODE_CTRL_EXTRA_LIFE_EN (one bonus life when score first crosses 10000)
module game_mode_ctrl #(
  parameter int N_ENEMIES     = 4,
  parameter int LIVES         = 3,
  parameter int PELLET_COUNT  = 244,
  parameter int LOAD_FRAMES   = 60,
  parameter int FAIL_FRAMES   = 90,
  parameter int WIN_FRAMES    = 120,
  parameter int FRIGHT_FRAMES = 360,
  parameter int CANDY_PTS     = 10,
  parameter int COOKIE_PTS    = 50,
  parameter int GHOST_PTS     = 200
) (
  input  logic                   vga_pix_clk,
  input  logic                   rst_n,
  input  logic                   frame_stb,
  input  logic                   btn_any,
  input  logic                   ate_candy_stb,
  input  logic                   ate_power_cookie_stb,
  input  logic [8:0]             x_pac,
  input  logic [8:0]             y_pac,
  input  logic [9*N_ENEMIES-1:0] x_enemy,
  input  logic [9*N_ENEMIES-1:0] y_enemy,
  output logic [2:0]             mode,
  output logic                   move_en,
  output logic [N_ENEMIES-1:0]   frightened,
  output logic [N_ENEMIES-1:0]   enemy_eaten_stb,
  output logic                   round_rst_stb,
  output logic                   level_rst_stb,
  output logic [15:0]            score,
  output logic [2:0]             lives,
  output logic [7:0]             level
);

  typedef enum logic [2:0] {
    LOADING         = 3'd0,
    READY           = 3'd1,
    GAME_PLAY       = 3'd2,
    BLUE_GHOST_MODE = 3'd3,
    FAIL            = 3'd4,
    WIN             = 3'd5,
    FINISH          = 3'd6
  } game_mode_t;

  game_mode_t           state;
  logic [15:0]          fcnt;
  logic [15:0]          dur_m1;
  logic [15:0]          pellets;
  logic [15:0]          pel_sum;
  logic [3:0]           mult;
  logic [3:0]           mult_nx;
  logic [N_ENEMIES-1:0] coll;
  logic [N_ENEMIES-1:0] eat_hit;
  logic [17:0]          ghost_add;
  logic [17:0]          pts_add;
  logic [17:0]          score_sum;
  logic [15:0]          score_sat;
  logic [2:0]           lives_nx;
  logic                 in_play;
  logic                 loss;
  logic                 win_hit;
  logic                 all_eaten;
  logic                 frame_done;
  logic                 bonus;

  assign mode = state;

  always_comb begin
    coll = '0;
    for (int i = 0; i < N_ENEMIES; i++) begin
      coll[i] = (x_pac == x_enemy[9*i +: 9]) && (y_pac == y_enemy[9*i +: 9]);
    end
  end

  assign in_play   = (state == GAME_PLAY) || (state == BLUE_GHOST_MODE);
  assign eat_hit   = (state == BLUE_GHOST_MODE) ? (coll & frightened) : '0;
  assign loss      = (state == GAME_PLAY) ? (|coll)
                   : (state == BLUE_GHOST_MODE) ? (|(coll & ~frightened)) : 1'b0;
  assign all_eaten = ((frightened & ~eat_hit) == '0);

  // Ghosts eaten in the same cycle are scored in index order, each doubling the multiplier.
  always_comb begin
    ghost_add = '0;
    mult_nx   = mult;
    for (int i = 0; i < N_ENEMIES; i++) begin
      if (eat_hit[i]) begin
        ghost_add = ghost_add + 18'(GHOST_PTS) * 18'(mult_nx);
        if (mult_nx != 4'd8) mult_nx = mult_nx << 1;
      end
    end
  end

  assign pts_add   = ((in_play && ate_candy_stb)        ? 18'(CANDY_PTS)  : 18'd0)
                   + ((in_play && ate_power_cookie_stb) ? 18'(COOKIE_PTS) : 18'd0);
  assign score_sum = {2'b00, score} + ghost_add + pts_add;
  assign score_sat = (score_sum > 18'h0FFFF) ? 16'hFFFF : score_sum[15:0];
  assign pel_sum   = pellets + 16'(in_play && ate_candy_stb) + 16'(in_play && ate_power_cookie_stb);
  assign win_hit   = in_play && (pel_sum >= 16'(PELLET_COUNT));

`ifdef GAME_MODE_CTRL_EXTRA_LIFE_EN
  logic bonus_used;
  assign bonus = in_play && !bonus_used && (score < 16'd10000) && (score_sat >= 16'd10000);
`else
  assign bonus = 1'b0;
`endif

  always_comb begin
    lives_nx = lives;
    if (loss) lives_nx = lives - 3'd1;
    if (bonus && (lives_nx != 3'd7) && (lives_nx != 3'd0)) lives_nx = lives_nx + 3'd1;
  end

  always_comb begin
    case (state)
      LOADING: dur_m1 = 16'(LOAD_FRAMES - 1);
      FAIL:    dur_m1 = 16'(FAIL_FRAMES - 1);
      WIN:     dur_m1 = 16'(WIN_FRAMES - 1);
      default: dur_m1 = 16'(FRIGHT_FRAMES - 1);
    endcase
  end
  assign frame_done = frame_stb && (fcnt == dur_m1);

  always_ff @(posedge vga_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= LOADING;
      fcnt            <= '0;
      pellets         <= '0;
      mult            <= 4'd1;
      score           <= '0;
      lives           <= 3'(LIVES);
      level           <= '0;
      frightened      <= '0;
      enemy_eaten_stb <= '0;
      round_rst_stb   <= 1'b0;
      level_rst_stb   <= 1'b0;
      move_en         <= 1'b0;
`ifdef GAME_MODE_CTRL_EXTRA_LIFE_EN
      bonus_used      <= 1'b0;
`endif
    end else begin
      enemy_eaten_stb <= eat_hit;
      round_rst_stb   <= 1'b0;
      level_rst_stb   <= 1'b0;
      if (in_play) begin
        score   <= score_sat;
        pellets <= pel_sum;
        lives   <= lives_nx;
`ifdef GAME_MODE_CTRL_EXTRA_LIFE_EN
        if (bonus) bonus_used <= 1'b1;
`endif
      end
      case (state)
        LOADING: if (frame_stb) begin
          fcnt <= frame_done ? 16'd0 : fcnt + 16'd1;
          if (frame_done) state <= READY;
        end
        READY: if (btn_any) begin
          state   <= GAME_PLAY;
          move_en <= 1'b1;
          fcnt    <= '0;
        end
        GAME_PLAY, BLUE_GHOST_MODE: begin
          // A lost life outranks the last pellet, which outranks a fresh cookie.
          if (loss) begin
            state      <= (lives == 3'd1) ? FINISH : FAIL;
            frightened <= '0;
            move_en    <= 1'b0;
            fcnt       <= '0;
          end else if (win_hit) begin
            state      <= WIN;
            frightened <= '0;
            move_en    <= 1'b0;
            fcnt       <= '0;
          end else if (ate_power_cookie_stb) begin
            state      <= BLUE_GHOST_MODE;
            frightened <= '1;
            mult       <= 4'd1;
            fcnt       <= '0;
          end else if (state == BLUE_GHOST_MODE) begin
            mult       <= mult_nx;
            frightened <= frightened & ~eat_hit;
            if (all_eaten || frame_done) begin
              state      <= GAME_PLAY;
              frightened <= '0;
              fcnt       <= '0;
            end else if (frame_stb) begin
              fcnt <= fcnt + 16'd1;
            end
          end
        end
        FAIL: if (frame_stb) begin
          fcnt <= frame_done ? 16'd0 : fcnt + 16'd1;
          if (frame_done) begin
            state         <= READY;
            round_rst_stb <= 1'b1;
          end
        end
        WIN: if (frame_stb) begin
          fcnt <= frame_done ? 16'd0 : fcnt + 16'd1;
          if (frame_done) begin
            state         <= LOADING;
            round_rst_stb <= 1'b1;
            level_rst_stb <= 1'b1;
            level         <= level + 8'd1;
            pellets       <= '0;
          end
        end
        FINISH: if (btn_any) begin
          state         <= LOADING;
          fcnt          <= '0;
          round_rst_stb <= 1'b1;
          level_rst_stb <= 1'b1;
          score         <= '0;
          lives         <= 3'(LIVES);
          level         <= '0;
          pellets       <= '0;
`ifdef GAME_MODE_CTRL_EXTRA_LIFE_EN
          bonus_used    <= 1'b0;
`endif
        end
        default: state <= LOADING;
      endcase
    end
  end

endmodule
